// File: rtl/mem_arbiter_if.sv
// Signal bundle between the memory arbiter, the IF/MEM pipeline stages and the SRAM pins.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 18,
  parameter int unsigned DATA_W = 16
);
  // Instruction fetch port
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ack;

  // Data access port
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_ack;

  // SRAM pins
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_dout_en;
  logic [DATA_W-1:0] ram_rdata;
  logic              ram_ce_n;
  logic              ram_oe_n;
  logic              ram_we_n;

  // Pipeline holds for the structural hazard
  logic              PC_pause;
  logic              ii_pause;
  logic              ie_pause;
  logic              em_pause;

  // Arbiter side
  modport slave (
    input  if_req, if_addr,
    output if_rdata, if_ack,
    input  dm_req, dm_we, dm_addr, dm_wdata,
    output dm_rdata, dm_ack,
    output ram_addr, ram_wdata, ram_dout_en,
    input  ram_rdata,
    output ram_ce_n, ram_oe_n, ram_we_n,
    output PC_pause, ii_pause, ie_pause, em_pause
  );

  // Pipeline / SRAM side
  modport master (
    output if_req, if_addr,
    input  if_rdata, if_ack,
    output dm_req, dm_we, dm_addr, dm_wdata,
    input  dm_rdata, dm_ack,
    input  ram_addr, ram_wdata, ram_dout_en,
    output ram_rdata,
    input  ram_ce_n, ram_oe_n, ram_we_n,
    input  PC_pause, ii_pause, ie_pause, em_pause
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one asynchronous SRAM between instruction fetch and data access.
// Data wins on collision; each access is a fixed ACC_CYCLES-long strobe
// sequence (one setup cycle, then strobe cycles) followed by a one-cycle ack.
module mem_arbiter #(
  parameter int unsigned ADDR_W     = 18,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned ACC_CYCLES = 2
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    DACC,
    IACC
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
  logic                dout_en_q, dout_en_d;
  logic                ce_n_q, ce_n_d;
  logic                oe_n_q, oe_n_d;
  logic                we_n_q, we_n_d;
  logic                if_ack_q, if_ack_d;
  logic                dm_ack_q, dm_ack_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   dm_rdata_q, dm_rdata_d;

  // A port is not re-granted in its own ack cycle.
  logic dm_elig_c;
  logic if_elig_c;
  assign dm_elig_c = bus.dm_req & ~dm_ack_q;
  assign if_elig_c = bus.if_req & ~if_ack_q;

  // State and output registers; reset aborts any in-flight access silently.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      wr_q        <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      dout_en_q   <= 1'b0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_q        <= wr_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      dout_en_q   <= dout_en_d;
      ce_n_q      <= ce_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      if_ack_q    <= if_ack_d;
      dm_ack_q    <= dm_ack_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
    end
  end

  // Grant, strobe sequencing and completion.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wr_d        = wr_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    dout_en_d   = dout_en_q;
    ce_n_d      = ce_n_q;
    oe_n_d      = oe_n_q;
    we_n_d      = we_n_q;
    if_ack_d    = 1'b0;
    dm_ack_d    = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;

    unique case (state_q)
      IDLE: begin
        if (dm_elig_c) begin
          state_d    = DACC;
          cnt_d      = '0;
          wr_d       = bus.dm_we;
          ram_addr_d = bus.dm_addr;
          ce_n_d     = 1'b0;
          if (bus.dm_we) begin
            // Drive data from setup onward; WE strobes from cycle 1.
            ram_wdata_d = bus.dm_wdata;
            dout_en_d   = 1'b1;
            oe_n_d      = 1'b1;
          end else begin
            oe_n_d      = 1'b0;
          end
        end else if (if_elig_c) begin
          state_d    = IACC;
          cnt_d      = '0;
          wr_d       = 1'b0;
          ram_addr_d = bus.if_addr;
          ce_n_d     = 1'b0;
          oe_n_d     = 1'b0;
        end
      end

      DACC, IACC: begin
        if (cnt_q == CNT_LAST) begin
          if (state_q == DACC) begin
            dm_ack_d = 1'b1;
            if (!wr_q) begin
              dm_rdata_d = bus.ram_rdata;
            end
          end else begin
            if_ack_d   = 1'b1;
            if_rdata_d = bus.ram_rdata;
          end
          state_d   = IDLE;
          cnt_d     = '0;
          ce_n_d    = 1'b1;
          oe_n_d    = 1'b1;
          we_n_d    = 1'b1;
          dout_en_d = 1'b0;
        end else begin
          cnt_d  = cnt_q + CNT_W'(1);
          we_n_d = ~wr_q;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Structural-hazard holds, released in the ack cycle.
  logic dm_busy_c;
  logic if_busy_c;
  assign dm_busy_c = bus.dm_req & ~dm_ack_q;
  assign if_busy_c = bus.if_req & ~if_ack_q;

  assign bus.em_pause = dm_busy_c;
  assign bus.ie_pause = dm_busy_c;
  assign bus.PC_pause = dm_busy_c | if_busy_c;
  assign bus.ii_pause = dm_busy_c | if_busy_c;

  // Registered outputs onto the bundle.
  assign bus.ram_addr    = ram_addr_q;
  assign bus.ram_wdata   = ram_wdata_q;
  assign bus.ram_dout_en = dout_en_q;
  assign bus.ram_ce_n    = ce_n_q;
  assign bus.ram_oe_n    = oe_n_q;
  assign bus.ram_we_n    = we_n_q;
  assign bus.if_ack      = if_ack_q;
  assign bus.dm_ack      = dm_ack_q;
  assign bus.if_rdata    = if_rdata_q;
  assign bus.dm_rdata    = dm_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (2- and 4-cycle accesses), each with a
// toy SRAM, a transaction-level reference model and a per-cycle compare.
module tb_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  bit done [2];

  task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (inst %0d) at %0t: got %0h expected %0h", nm, inst, $time, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int ACC = (g == 0) ? 2 : 4;

    logic rst_g;
    mem_arbiter_if #(.ADDR_W(18), .DATA_W(16)) bus ();

    mem_arbiter #(.ADDR_W(18), .DATA_W(16), .ACC_CYCLES(ACC)) u_dut (
      .clk (clk),
      .rst (rst_g),
      .bus (bus)
    );

    // Toy SRAM indexed by the low address bits; floats a marker when not read.
    logic [15:0] sram [32];
    assign bus.ram_rdata = (!bus.ram_ce_n && !bus.ram_oe_n) ? sram[bus.ram_addr[4:0]] : 16'hDEAD;
    always @(posedge clk) begin
      if (!bus.ram_ce_n && !bus.ram_we_n && bus.ram_dout_en)
        sram[bus.ram_addr[4:0]] = bus.ram_wdata;
    end

    // Reference model: one access record with its start cycle, an ack slot,
    // and the memory contents as the pipeline should see them.
    logic [15:0] mm [32];
    int          cyc = 0;
    bit          act = 1'b0;
    int          a_s = 0;
    bit          a_d = 1'b0;
    bit          a_we = 1'b0;
    logic [17:0] a_addr = '0;
    logic [15:0] a_wd = '0;
    int          ack_cyc = -10;
    bit          ack_d = 1'b0;
    logic [17:0] e_addr = '0;
    logic [15:0] e_wd = '0;
    logic [15:0] e_if_rd = '0;
    logic [15:0] e_dm_rd = '0;

    always @(posedge clk or negedge rst_g) begin
      if (!rst_g) begin
        cyc = 0; act = 1'b0; ack_cyc = -10;
        e_addr = '0; e_wd = '0; e_if_rd = '0; e_dm_rd = '0;
      end else begin
        if (act && cyc == a_s + ACC - 1) begin
          if (a_we) mm[a_addr[4:0]] = a_wd;
          else if (a_d) e_dm_rd = mm[a_addr[4:0]];
          else e_if_rd = mm[a_addr[4:0]];
          act = 1'b0; ack_cyc = cyc + 1; ack_d = a_d;
        end else if (!act) begin
          if (bus.dm_req && !(ack_cyc == cyc && ack_d)) begin
            act = 1'b1; a_s = cyc + 1; a_d = 1'b1; a_we = bus.dm_we;
            a_addr = bus.dm_addr; a_wd = bus.dm_wdata; e_addr = bus.dm_addr;
            if (bus.dm_we) e_wd = bus.dm_wdata;
          end else if (bus.if_req && !(ack_cyc == cyc && !ack_d)) begin
            act = 1'b1; a_s = cyc + 1; a_d = 1'b0; a_we = 1'b0;
            a_addr = bus.if_addr; e_addr = bus.if_addr;
          end
        end
        cyc++;
      end
    end

    // Per-cycle compare of every output against the model.
    bit in_acc, x_if_ack, x_dm_ack, x_dm_busy, x_if_busy;
    always @(negedge clk) begin
      in_acc    = act && (cyc >= a_s) && (cyc <= a_s + ACC - 1);
      x_if_ack  = (ack_cyc == cyc) && !ack_d;
      x_dm_ack  = (ack_cyc == cyc) && ack_d;
      x_dm_busy = bus.dm_req && !x_dm_ack;
      x_if_busy = bus.if_req && !x_if_ack;
      chk("ram_ce_n",    g, 32'(bus.ram_ce_n),    32'(!in_acc));
      chk("ram_oe_n",    g, 32'(bus.ram_oe_n),    32'(!(in_acc && !a_we)));
      chk("ram_we_n",    g, 32'(bus.ram_we_n),    32'(!(in_acc && a_we && cyc > a_s)));
      chk("ram_dout_en", g, 32'(bus.ram_dout_en), 32'(in_acc && a_we));
      chk("ram_addr",    g, 32'(bus.ram_addr),    32'(e_addr));
      chk("ram_wdata",   g, 32'(bus.ram_wdata),   32'(e_wd));
      chk("if_ack",      g, 32'(bus.if_ack),      32'(x_if_ack));
      chk("dm_ack",      g, 32'(bus.dm_ack),      32'(x_dm_ack));
      chk("if_rdata",    g, 32'(bus.if_rdata),    32'(e_if_rd));
      chk("dm_rdata",    g, 32'(bus.dm_rdata),    32'(e_dm_rd));
      chk("em_pause",    g, 32'(bus.em_pause),    32'(x_dm_busy));
      chk("ie_pause",    g, 32'(bus.ie_pause),    32'(x_dm_busy));
      chk("PC_pause",    g, 32'(bus.PC_pause),    32'(x_dm_busy || x_if_busy));
      chk("ii_pause",    g, 32'(bus.ii_pause),    32'(x_dm_busy || x_if_busy));
    end

    // Directed scenarios with literal expectations, then random traffic.
    initial begin
      logic [15:0] v;
      rst_g = 1'b0;
      bus.if_req = 1'b0; bus.if_addr = '0;
      bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '0;
      for (int i = 0; i < 32; i++) begin
        v = 16'($urandom);
        sram[i] = v; mm[i] = v;
      end
      sram[16] = 16'hA5A5; mm[16] = 16'hA5A5;
      sram[17] = 16'h5A5A; mm[17] = 16'h5A5A;
      sram[0]  = 16'h1234; mm[0]  = 16'h1234;

      // Reset held with random inputs
      for (int c = 0; c < 3; c++) begin
        next_cycle();
        bus.if_req = 1'($urandom); bus.dm_req = 1'($urandom); bus.dm_we = 1'($urandom);
        bus.if_addr = 18'($urandom); bus.dm_addr = 18'($urandom); bus.dm_wdata = 16'($urandom);
        @(negedge clk);
        chk("rst_ce_n", g, 32'(bus.ram_ce_n), 32'd1);
        chk("rst_dout_en", g, 32'(bus.ram_dout_en), 32'd0);
        chk("rst_acks", g, 32'({bus.if_ack, bus.dm_ack}), 32'd0);
      end
      next_cycle();
      bus.if_req = 1'b0; bus.dm_req = 1'b0; bus.dm_we = 1'b0;
      rst_g = 1'b1;
      next_cycle();

      // Single fetch; req held through its ack cycle must not be re-granted
      bus.if_req = 1'b1; bus.if_addr = 18'h00010;
      for (int c = 0; c <= ACC + 2; c++) begin
        if (c == ACC + 2) bus.if_req = 1'b0;
        @(negedge clk);
        chk("fetch_ce_n", g, 32'(bus.ram_ce_n), 32'(!(c >= 1 && c <= ACC)));
        chk("fetch_oe_n", g, 32'(bus.ram_oe_n), 32'(!(c >= 1 && c <= ACC)));
        chk("fetch_ack", g, 32'(bus.if_ack), 32'(c == ACC + 1));
        chk("fetch_pause", g, 32'(bus.PC_pause), 32'(c <= ACC));
        if (c == ACC + 1) chk("fetch_rdata", g, 32'(bus.if_rdata), 32'h0000A5A5);
        next_cycle();
      end

      // Collision: data first, fetch one idle cycle after the data ack
      bus.if_req = 1'b1; bus.if_addr = 18'h00011;
      bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 18'h00020;
      for (int c = 0; c <= 2 * ACC + 3; c++) begin
        if (c == ACC + 2) bus.dm_req = 1'b0;
        if (c == 2 * ACC + 3) bus.if_req = 1'b0;
        @(negedge clk);
        chk("coll_dm_ack", g, 32'(bus.dm_ack), 32'(c == ACC + 1));
        chk("coll_if_ack", g, 32'(bus.if_ack), 32'(c == 2 * ACC + 2));
        chk("coll_em_pause", g, 32'(bus.em_pause), 32'(c <= ACC));
        chk("coll_pc_pause", g, 32'(bus.PC_pause), 32'(c <= 2 * ACC + 1));
        if (c >= 1 && c <= ACC) chk("coll_daddr", g, 32'(bus.ram_addr), 32'h20);
        if (c >= ACC + 2 && c <= 2 * ACC + 1) chk("coll_iaddr", g, 32'(bus.ram_addr), 32'h11);
        if (c == ACC + 1) chk("coll_dm_rdata", g, 32'(bus.dm_rdata), 32'h00001234);
        if (c == 2 * ACC + 2) chk("coll_if_rdata", g, 32'(bus.if_rdata), 32'h00005A5A);
        next_cycle();
      end

      // Write strobe at the top address
      bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 18'h3FFFF; bus.dm_wdata = 16'hBEEF;
      for (int c = 0; c <= ACC + 2; c++) begin
        if (c == ACC + 2) bus.dm_req = 1'b0;
        @(negedge clk);
        chk("wr_we_n", g, 32'(bus.ram_we_n), 32'(!(c >= 2 && c <= ACC)));
        chk("wr_dout_en", g, 32'(bus.ram_dout_en), 32'(c >= 1 && c <= ACC));
        chk("wr_oe_n", g, 32'(bus.ram_oe_n), 32'd1);
        chk("wr_ack", g, 32'(bus.dm_ack), 32'(c == ACC + 1));
        chk("wr_rdata_kept", g, 32'(bus.dm_rdata), 32'h00001234);
        if (c >= 1 && c <= ACC) chk("wr_wdata", g, 32'(bus.ram_wdata), 32'h0000BEEF);
        next_cycle();
      end

      // Read the written word back
      bus.dm_we = 1'b0; bus.dm_req = 1'b1;
      for (int c = 0; c <= ACC + 1; c++) begin
        if (c == ACC + 1) bus.dm_req = 1'b0;
        @(negedge clk);
        if (c == ACC + 1) chk("rdback", g, 32'(bus.dm_rdata), 32'h0000BEEF);
        next_cycle();
      end

      // Reset in the second data-access cycle aborts without an ack
      bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 18'h00020;
      for (int c = 0; c <= ACC + 4; c++) begin
        if (c == 2) begin
          chk("pre_rst_ce_n", g, 32'(bus.ram_ce_n), 32'd0);
          rst_g = 1'b0;
          #1;
          chk("async_ce_n", g, 32'(bus.ram_ce_n), 32'd1);
          chk("async_oe_n", g, 32'(bus.ram_oe_n), 32'd1);
        end
        if (c == 3) rst_g = 1'b1;
        @(negedge clk);
        chk("rst_abort_ack", g, 32'(bus.dm_ack), 32'(c == ACC + 4));
        if (c == ACC + 4) chk("rst_fresh_rdata", g, 32'(bus.dm_rdata), 32'h00001234);
        next_cycle();
      end
      bus.dm_req = 1'b0;
      next_cycle();

      // Random traffic
      for (int i = 0; i < 400; i++) begin
        bus.if_req   = ($urandom_range(0, 3) != 0);
        bus.dm_req   = ($urandom_range(0, 2) == 0);
        bus.dm_we    = 1'($urandom);
        bus.if_addr  = 18'($urandom);
        bus.dm_addr  = 18'($urandom);
        bus.dm_wdata = 16'($urandom);
        next_cycle();
      end
      bus.if_req = 1'b0; bus.dm_req = 1'b0;
      repeat (2 * ACC + 4) next_cycle();
      done[g] = 1'b1;
    end
  end

  initial begin
    int waited;
    waited = 0;
    while (!(done[0] && done[1]) && waited < 20000) begin
      @(posedge clk);
      waited++;
    end
    if (!(done[0] && done[1])) begin
      n_cmp++;
      n_err++;
      $display("FAIL timeout: got %0d cycles waited expected completion", waited);
    end
    #20;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
